// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared types and constants for the LCD pixel path: the RGB565 pixel
//   layout, the colour shown on FIFO underflow, the resync FSM states and
//   the panel timing numbers also used by the LCDC timing generator.
package lcd_pkg;

  // RGB565 pixel, MSB first: {r[4:0], g[5:0], b[4:0]}
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Solid red makes a starved panel obvious on screen
  localparam logic [15:0] LCD_UNDERFLOW_RGB = 16'hF800;

  // Frame resync state of the pixel FIFO
  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } fifo_state_e;

  // Panel timing (480x272 class panel), shared with the LCDC
  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_FP     = 2;
  localparam int LCD_H_SYNC   = 41;
  localparam int LCD_H_BP     = 2;
  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_FP     = 2;
  localparam int LCD_V_SYNC   = 10;
  localparam int LCD_V_BP     = 2;

endpackage

// File: rtl/lcd_fifo_ram.sv
// lcd_fifo_ram
//   DEPTH x 16 simple dual-port memory with a registered read port. Small
//   enough to land in distributed RAM or a single EBR.
// Ports:
//   pclk     - clock, rising edge
//   rst      - asynchronous active-low reset (read register only)
//   wr_en    - write strobe; wr_addr/wr_data written on the rising edge
//   rd_en    - read strobe; rd_data loads mem[rd_addr] on the rising edge
//   rd_data  - registered read data, holds while rd_en is low
module lcd_fifo_ram #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [DEPTH];

  // Storage array has no reset so it can map onto RAM primitives
  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register is reset so the LCDC sees black out of reset
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)       rd_data <= 16'h0000;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_pixel_fifo.sv
// lcd_pixel_fifo
//   Elastic RGB565 buffer in front of the LCDC timing generator. Accepts
//   pixels over valid/ready, delivers one per pix_req with one cycle of
//   latency, flushes on each VSYNC falling edge and then waits for a
//   start-of-frame pixel, and flags underflow with a sticky bit.
// Ports:
//   pclk, rst            - pixel clock; asynchronous active-low reset
//   in_valid/in_ready    - producer handshake; in_data RGB565, in_sof marks
//                          the first pixel of a frame
//   pix_req              - LCDC asks for the next pixel
//   vsync                - LCDC VSYNC, active-low pulse
//   pix_data, pix_r/g/b  - pixel to the LCDC, valid the cycle after pix_req
//   underflow            - sticky: pix_req arrived while empty
//   underflow_clr        - synchronous clear of underflow
//   level                - occupancy 0..DEPTH
module lcd_pixel_fifo
  import lcd_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] UNDERFLOW_RGB = LCD_UNDERFLOW_RGB,
  localparam int         AW            = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  input  logic          in_sof,
  input  logic          pix_req,
  input  logic          vsync,
  output logic [15:0]   pix_data,
  output logic [4:0]    pix_r,
  output logic [5:0]    pix_g,
  output logic [4:0]    pix_b,
  output logic          underflow,
  input  logic          underflow_clr,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_state_e state, state_next;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        vsync_q;
  logic        show_uf;
  logic        full, empty, vs_fall;
  logic        wr_en, rd_en, uf_evt;
  logic [15:0] ram_q;
  rgb565_t     pix_s;

  assign vs_fall = vsync_q && !vsync;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;

  // While waiting for a frame start every offered pixel is taken, so the
  // producer drains up to its sof; only the sof pixel is actually stored.
  always_comb begin
    in_ready = 1'b0;
    if (state == RUN) in_ready = !full;
    else              in_ready = in_valid && (!in_sof || !full);
  end

  // Handshakes in the flush cycle are dropped
  assign wr_en  = in_valid && in_ready && (state == RUN || in_sof) && !vs_fall;
  assign rd_en  = pix_req && !empty && !vs_fall;
  assign uf_evt = pix_req && empty && !vs_fall;

  always_comb begin
    state_next = state;
    if (vs_fall)                                   state_next = SYNC_WAIT;
    else if (state == SYNC_WAIT && in_valid && in_sof) state_next = RUN;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= SYNC_WAIT;
    else      state <= state_next;
  end

  // Pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
      if (vs_fall) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // show_uf selects the underflow colour in place of the RAM output; it
  // is only replaced by a real read, so pix_data holds without pix_req.
  // A new underflow beats a simultaneous clear.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      show_uf   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (uf_evt)     show_uf <= 1'b1;
      else if (rd_en) show_uf <= 1'b0;
      if (uf_evt)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

  lcd_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .pclk    (pclk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  assign pix_data = show_uf ? UNDERFLOW_RGB : ram_q;
  assign pix_s    = pix_data;
  assign pix_r    = pix_s.r;
  assign pix_g    = pix_s.g;
  assign pix_b    = pix_s.b;

endmodule
